// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master, five-slave AXI read sequencer with one outstanding burst.
//   M0/M1 AR in  : ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID, ARREADY out (combinational grant)
//   M0/M1 R out  : RID/RDATA/RRESP/RLAST/RVALID, RREADY in
//   Slave AR out : shared ARID_S({tag,id})/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S, one-hot ARVALID_S, ARREADY_S in
//   Slave R in   : packed RID_S/RDATA_S/RRESP_S, per-slave RLAST_S/RVALID_S, RREADY_S out
//   Unmapped addresses get an internal DECERR burst of ARLEN+1 beats.
module axi_read_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int NS        = 5
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_BITS-1:0]      ARID_M0,
    input  logic [ADDR_BITS-1:0]    ARADDR_M0,
    input  logic [LEN_BITS-1:0]     ARLEN_M0,
    input  logic [2:0]              ARSIZE_M0,
    input  logic [1:0]              ARBURST_M0,
    input  logic                    ARVALID_M0,
    output logic                    ARREADY_M0,
    input  logic [ID_BITS-1:0]      ARID_M1,
    input  logic [ADDR_BITS-1:0]    ARADDR_M1,
    input  logic [LEN_BITS-1:0]     ARLEN_M1,
    input  logic [2:0]              ARSIZE_M1,
    input  logic [1:0]              ARBURST_M1,
    input  logic                    ARVALID_M1,
    output logic                    ARREADY_M1,
    output logic [ID_BITS-1:0]      RID_M0,
    output logic [DATA_BITS-1:0]    RDATA_M0,
    output logic [1:0]              RRESP_M0,
    output logic                    RLAST_M0,
    output logic                    RVALID_M0,
    input  logic                    RREADY_M0,
    output logic [ID_BITS-1:0]      RID_M1,
    output logic [DATA_BITS-1:0]    RDATA_M1,
    output logic [1:0]              RRESP_M1,
    output logic                    RLAST_M1,
    output logic                    RVALID_M1,
    input  logic                    RREADY_M1,
    output logic [IDS_BITS-1:0]     ARID_S,
    output logic [ADDR_BITS-1:0]    ARADDR_S,
    output logic [LEN_BITS-1:0]     ARLEN_S,
    output logic [2:0]              ARSIZE_S,
    output logic [1:0]              ARBURST_S,
    output logic [NS-1:0]           ARVALID_S,
    input  logic [NS-1:0]           ARREADY_S,
    input  logic [NS*IDS_BITS-1:0]  RID_S,
    input  logic [NS*DATA_BITS-1:0] RDATA_S,
    input  logic [NS*2-1:0]         RRESP_S,
    input  logic [NS-1:0]           RLAST_S,
    input  logic [NS-1:0]           RVALID_S,
    output logic [NS-1:0]           RREADY_S
);
    localparam int SW = $clog2(NS);
    localparam int TW = IDS_BITS - ID_BITS;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} state_t;

    state_t               r_state;
    logic                 r_gnt_m1;
    logic [SW-1:0]        r_sel;
    logic [TW-1:0]        r_tag;
    logic [ID_BITS-1:0]   r_id;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]  r_len;
    logic [LEN_BITS-1:0]  r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [NS-1:0]        r_arvalid_s;

    logic                 w_any;
    logic                 w_gnt_m1;
    logic                 w_hit;
    logic [NS-1:0]        w_dec;
    logic [SW-1:0]        w_idx;
    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_rvalid;
    logic                 w_rlast;
    logic                 w_rready;
    logic [ID_BITS-1:0]   w_rid;
    logic [DATA_BITS-1:0] w_rdata;
    logic [1:0]           w_rresp;
    logic                 w_unused;

    logic [ID_BITS-1:0]   w_rid_s   [NS];
    logic [DATA_BITS-1:0] w_rdata_s [NS];
    logic [1:0]           w_rresp_s [NS];

    for (genvar i = 0; i < NS; i++) begin : g_unpack
        assign w_rid_s[i]   = RID_S[i*IDS_BITS +: ID_BITS];
        assign w_rdata_s[i] = RDATA_S[i*DATA_BITS +: DATA_BITS];
        assign w_rresp_s[i] = RRESP_S[i*2 +: 2];
    end

    // Slave-side tag bits of RID are not returned to the masters.
    assign w_unused = ^RID_S;

    // r_gnt_m1 doubles as the last-grant record: reset to M1 so M0 wins the first tie.
    assign w_any    = ARVALID_M0 | ARVALID_M1;
    assign w_gnt_m1 = ARVALID_M1 & (~ARVALID_M0 | ~r_gnt_m1);
    assign w_addr   = w_gnt_m1 ? ARADDR_M1 : ARADDR_M0;

    assign w_dec[0] = w_addr[31:13] == 19'h0;
    assign w_dec[1] = w_addr[31:16] == 16'h0001;
    assign w_dec[2] = w_addr[31:16] == 16'h0002;
    assign w_dec[3] = w_addr[31:10] == 22'h04_0000;
    assign w_dec[4] = w_addr[31:21] == 11'h100;
    assign w_hit    = |w_dec;
    assign w_idx    = w_dec[0] ? SW'(0) : w_dec[1] ? SW'(1) : w_dec[2] ? SW'(2) :
                      w_dec[3] ? SW'(3) : SW'(4);

    // Reset also masks the combinational grant so every output reads 0 while ARESETn is low.
    assign ARREADY_M0 = ARESETn && r_state == IDLE && ARVALID_M0 && !w_gnt_m1;
    assign ARREADY_M1 = ARESETn && r_state == IDLE && w_gnt_m1;

    assign ARID_S    = {r_tag, r_id};
    assign ARADDR_S  = r_addr;
    assign ARLEN_S   = r_len;
    assign ARSIZE_S  = r_size;
    assign ARBURST_S = r_burst;
    assign ARVALID_S = r_arvalid_s;

    assign w_rready = r_gnt_m1 ? RREADY_M1 : RREADY_M0;

    always_comb begin
        w_rvalid = 1'b0;
        w_rlast  = 1'b0;
        w_rid    = '0;
        w_rdata  = '0;
        w_rresp  = '0;
        if (r_state == DATA) begin
            w_rvalid = RVALID_S[r_sel];
            w_rlast  = RLAST_S[r_sel];
            w_rid    = w_rid_s[r_sel];
            w_rdata  = w_rdata_s[r_sel];
            w_rresp  = w_rresp_s[r_sel];
        end else if (r_state == DERR) begin
            w_rvalid = 1'b1;
            w_rlast  = r_cnt == r_len;
            w_rid    = r_id;
            w_rresp  = 2'b11;
        end
    end

    assign RREADY_S = (r_state == DATA) ? (NS'(w_rready) << r_sel) : '0;

    assign RVALID_M0 = w_rvalid & ~r_gnt_m1;
    assign RLAST_M0  = w_rlast & ~r_gnt_m1;
    assign RID_M0    = r_gnt_m1 ? '0 : w_rid;
    assign RDATA_M0  = r_gnt_m1 ? '0 : w_rdata;
    assign RRESP_M0  = r_gnt_m1 ? '0 : w_rresp;
    assign RVALID_M1 = w_rvalid & r_gnt_m1;
    assign RLAST_M1  = w_rlast & r_gnt_m1;
    assign RID_M1    = r_gnt_m1 ? w_rid : '0;
    assign RDATA_M1  = r_gnt_m1 ? w_rdata : '0;
    assign RRESP_M1  = r_gnt_m1 ? w_rresp : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_gnt_m1    <= 1'b1;
            r_sel       <= '0;
            r_tag       <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_arvalid_s <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_gnt_m1    <= w_gnt_m1;
                    r_tag       <= w_gnt_m1 ? TW'(2) : TW'(1);
                    r_id        <= w_gnt_m1 ? ARID_M1 : ARID_M0;
                    r_addr      <= w_addr;
                    r_len       <= w_gnt_m1 ? ARLEN_M1 : ARLEN_M0;
                    r_size      <= w_gnt_m1 ? ARSIZE_M1 : ARSIZE_M0;
                    r_burst     <= w_gnt_m1 ? ARBURST_M1 : ARBURST_M0;
                    r_sel       <= w_idx;
                    r_cnt       <= '0;
                    r_arvalid_s <= w_hit ? (NS'(1) << w_idx) : '0;
                    r_state     <= w_hit ? ADDR : DERR;
                end
                ADDR: if (ARREADY_S[r_sel]) begin
                    r_arvalid_s <= '0;
                    r_state     <= DATA;
                end
                DATA: if (w_rvalid && w_rready && w_rlast) r_state <= IDLE;
                DERR: if (w_rready) begin
                    r_cnt   <= w_rlast ? '0 : r_cnt + 1'b1;
                    r_state <= w_rlast ? IDLE : DERR;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: vector table, reset corner case and random bursts against a transaction-level model.
module tb_axi_read_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   arid_m0 = '0, arid_m1 = '0;
    logic [31:0]  araddr_m0 = '0, araddr_m1 = '0;
    logic [3:0]   arlen_m0 = '0, arlen_m1 = '0;
    logic [2:0]   arsize_m0 = '0, arsize_m1 = '0;
    logic [1:0]   arburst_m0 = '0, arburst_m1 = '0;
    logic         arvalid_m0 = 1'b0, arvalid_m1 = 1'b0;
    logic         arready_m0, arready_m1;
    logic [3:0]   rid_m0, rid_m1;
    logic [31:0]  rdata_m0, rdata_m1;
    logic [1:0]   rresp_m0, rresp_m1;
    logic         rlast_m0, rlast_m1, rvalid_m0, rvalid_m1;
    logic         rready_m0 = 1'b0, rready_m1 = 1'b0;
    logic [7:0]   arid_s;
    logic [31:0]  araddr_s;
    logic [3:0]   arlen_s;
    logic [2:0]   arsize_s;
    logic [1:0]   arburst_s;
    logic [4:0]   arvalid_s;
    logic [4:0]   arready_s = '0;
    logic [39:0]  rid_s = '0;
    logic [159:0] rdata_s = '0;
    logic [9:0]   rresp_s = '0;
    logic [4:0]   rlast_s = '0, rvalid_s = '0;
    logic [4:0]   rready_s;

    axi_read_arbiter dut (
        .ACLK(clk), .ARESETn(rst_n),
        .ARID_M0(arid_m0), .ARADDR_M0(araddr_m0), .ARLEN_M0(arlen_m0), .ARSIZE_M0(arsize_m0),
        .ARBURST_M0(arburst_m0), .ARVALID_M0(arvalid_m0), .ARREADY_M0(arready_m0),
        .ARID_M1(arid_m1), .ARADDR_M1(araddr_m1), .ARLEN_M1(arlen_m1), .ARSIZE_M1(arsize_m1),
        .ARBURST_M1(arburst_m1), .ARVALID_M1(arvalid_m1), .ARREADY_M1(arready_m1),
        .RID_M0(rid_m0), .RDATA_M0(rdata_m0), .RRESP_M0(rresp_m0), .RLAST_M0(rlast_m0),
        .RVALID_M0(rvalid_m0), .RREADY_M0(rready_m0),
        .RID_M1(rid_m1), .RDATA_M1(rdata_m1), .RRESP_M1(rresp_m1), .RLAST_M1(rlast_m1),
        .RVALID_M1(rvalid_m1), .RREADY_M1(rready_m1),
        .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
        .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(arready_s),
        .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s), .RLAST_S(rlast_s),
        .RVALID_S(rvalid_s), .RREADY_S(rready_s)
    );

    typedef struct {
        bit          v0, v1;
        logic [3:0]  id0, id1;
        logic [31:0] a0, a1;
        logic [3:0]  l0, l1;
        int          ardly;
        int          mode;
        int          exp_win;
        int          exp_slv;
    } vec_t;

    localparam logic [31:0] LO [5] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h2000_0000};
    localparam logic [31:0] HI [5] = '{32'h0000_1FFF, 32'h0001_FFFF, 32'h0002_FFFF, 32'h1000_03FF, 32'h201F_FFFF};

    int   n_checks = 0;
    int   n_fail = 0;
    int   last_win = 1;
    vec_t tbl [15];
    vec_t rv;
    int   w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_slave(input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (a >= LO[i] && a <= HI[i]) return i;
        return -1;
    endfunction

    function automatic int ref_winner(input bit v0, input bit v1);
        return (v0 && v1) ? 1 - last_win : (v1 ? 1 : 0);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 32'($urandom_range(0, 32'h1FFF));
            1: return 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
            2: return 32'h0002_0000 + 32'($urandom_range(0, 32'hFFFF));
            3: return 32'h1000_0000 + 32'($urandom_range(0, 32'h3FF));
            4: return 32'h2000_0000 + 32'($urandom_range(0, 32'h1F_FFFF));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_txn(input vec_t v, input int win, input int slv);
        logic [3:0]  id, len, tag;
        logic [31:0] addr, dat;
        logic [1:0]  resp;
        logic [4:0]  oh;
        int          b, c;
        bit          rdy;
        id   = win ? v.id1 : v.id0;
        addr = win ? v.a1 : v.a0;
        len  = win ? v.l1 : v.l0;
        tag  = win ? 4'h2 : 4'h1;
        oh   = (slv >= 0) ? 5'(1 << slv) : 5'h0;
        @(negedge clk);
        arvalid_m0 = v.v0; arid_m0 = v.id0; araddr_m0 = v.a0; arlen_m0 = v.l0; arsize_m0 = 3'd2; arburst_m0 = 2'b01;
        arvalid_m1 = v.v1; arid_m1 = v.id1; araddr_m1 = v.a1; arlen_m1 = v.l1; arsize_m1 = 3'd1; arburst_m1 = 2'b10;
        #1;
        chk("idle_arready_m0", arready_m0, win == 0);
        chk("idle_arready_m1", arready_m1, win == 1);
        chk("idle_rvalid_bubble", {rvalid_m0, rvalid_m1}, 2'b00);
        chk("idle_rready_s", rready_s, 5'h0);
        chk("idle_arvalid_s", arvalid_s, 5'h0);
        last_win = win;
        @(negedge clk);
        rvalid_s = '1; rlast_s = '1; rready_m0 = 1'b1; rready_m1 = 1'b1;
        if (slv >= 0) begin
            for (int d = 0; d <= v.ardly; d++) begin
                arready_s = (d == v.ardly) ? oh : ~oh;
                #1;
                chk("addr_arvalid_s", arvalid_s, oh);
                chk("addr_arid_s", arid_s, {tag, id});
                chk("addr_araddr_s", araddr_s, addr);
                chk("addr_arlen_s", arlen_s, len);
                chk("addr_arsize_burst", {arsize_s, arburst_s}, win ? 5'b001_10 : 5'b010_01);
                chk("addr_no_arready", {arready_m0, arready_m1}, 2'b00);
                chk("addr_r_quiet", {rvalid_m0, rvalid_m1, rready_s}, 7'h0);
                @(negedge clk);
            end
            arready_s = '0;
        end
        b = 0;
        c = 0;
        while (b <= int'(len) && c < 200) begin
            rdy = (v.mode == 0) ? 1'b1 : (v.mode == 2) ? !(c == 1 || c == 2) : ($urandom_range(0, 3) != 0);
            rready_m0 = win ? !rdy : rdy;
            rready_m1 = win ? rdy : !rdy;
            dat  = $urandom;
            resp = 2'($urandom_range(0, 1));
            rvalid_s = '1;
            rlast_s  = (b == int'(len)) ? oh : ~oh;
            rdata_s  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rid_s    = 40'({$urandom, $urandom});
            rresp_s  = 10'($urandom);
            if (slv >= 0) begin
                rdata_s[slv*32 +: 32] = dat;
                rid_s[slv*8 +: 8]     = {tag, id};
                rresp_s[slv*2 +: 2]   = resp;
            end
            #1;
            chk("r_valid", win ? rvalid_m1 : rvalid_m0, 1'b1);
            chk("r_other_master", win ? {rvalid_m0, rlast_m0, rresp_m0, rdata_m0, rid_m0}
                                      : {rvalid_m1, rlast_m1, rresp_m1, rdata_m1, rid_m1}, 40'h0);
            chk("r_data", win ? rdata_m1 : rdata_m0, (slv >= 0) ? dat : 32'h0);
            chk("r_resp", win ? rresp_m1 : rresp_m0, (slv >= 0) ? resp : 2'b11);
            chk("r_last", win ? rlast_m1 : rlast_m0, b == int'(len));
            chk("r_id", win ? rid_m1 : rid_m0, id);
            chk("r_rready_s", rready_s, rdy ? oh : 5'h0);
            chk("r_arvalid_s", arvalid_s, 5'h0);
            if (rdy) b++;
            c++;
            if (b <= int'(len)) @(negedge clk);
        end
        chk("burst_beats", b, int'(len) + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        // {v0, v1, id0, id1, a0, a1, l0, l1, ardly, mode, exp_win, exp_slv}
        tbl[0]  = '{1, 1, 4'h3, 4'h5, 32'h0000_0100, 32'h0002_0000, 4'd1, 4'd2, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 4'h3, 4'h5, 32'h0000_0200, 32'h0002_0004, 4'd1, 4'd2, 1, 0, 1, 2};
        tbl[2]  = '{1, 1, 4'h7, 4'h8, 32'h1000_0000, 32'h0000_0000, 4'd0, 4'd1, 0, 0, 0, 3};
        tbl[3]  = '{1, 0, 4'h6, 4'h0, 32'h0001_0040, 32'h0000_0000, 4'd3, 4'd0, 0, 0, 0, 1};
        tbl[4]  = '{0, 1, 4'h0, 4'hA, 32'h0000_0000, 32'h3000_0000, 4'd0, 4'd2, 0, 2, 1, -1};
        tbl[5]  = '{0, 1, 4'h0, 4'hB, 32'h0000_0000, 32'h2000_0010, 4'd0, 4'd1, 5, 0, 1, 4};
        tbl[6]  = '{1, 0, 4'hC, 4'h0, 32'h0002_0080, 32'h0000_0000, 4'd7, 4'd0, 0, 1, 0, 2};
        tbl[7]  = '{1, 0, 4'h1, 4'h0, 32'h0000_1FFF, 32'h0000_0000, 4'd0, 4'd0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 4'h2, 4'h0, 32'h0000_2000, 32'h0000_0000, 4'd1, 4'd0, 0, 0, 0, -1};
        tbl[9]  = '{0, 1, 4'h0, 4'h3, 32'h0000_0000, 32'h1000_03FF, 4'd0, 4'd1, 0, 0, 1, 3};
        tbl[10] = '{0, 1, 4'h0, 4'h4, 32'h0000_0000, 32'h1000_0400, 4'd0, 4'd1, 0, 1, 1, -1};
        tbl[11] = '{1, 0, 4'hD, 4'h0, 32'h201F_FFFF, 32'h0000_0000, 4'd2, 4'd0, 2, 0, 0, 4};
        tbl[12] = '{0, 1, 4'h0, 4'hE, 32'h0000_0000, 32'h2020_0000, 4'd0, 4'd0, 0, 0, 1, -1};
        tbl[13] = '{1, 0, 4'hF, 4'h0, 32'h0001_FFFF, 32'h0000_0000, 4'd15, 4'd0, 0, 1, 0, 1};
        tbl[14] = '{0, 1, 4'h0, 4'h9, 32'h0000_0000, 32'h0003_0000, 4'd0, 4'd1, 0, 0, 1, -1};

        #2;
        arvalid_m0 = 1'b1;
        arvalid_m1 = 1'b1;
        #1;
        chk("reset_arready", {arready_m0, arready_m1}, 2'b00);
        chk("reset_r_out", {rvalid_m0, rvalid_m1, rlast_m0, rlast_m1, rdata_m0, rdata_m1}, 68'h0);
        chk("reset_s_out", {arvalid_s, rready_s, arid_s, araddr_s}, 50'h0);
        @(negedge clk);
        rst_n = 1'b1;
        arvalid_m0 = 1'b0;
        arvalid_m1 = 1'b0;

        for (int i = 0; i < 15; i++) run_txn(tbl[i], tbl[i].exp_win, tbl[i].exp_slv);

        rv = '{0, 1, 4'h0, 4'h9, 32'h0000_0000, 32'h2000_0100, 4'd0, 4'd7, 0, 0, 1, 4};
        @(negedge clk);
        rvalid_s = '0; rlast_s = '0; arvalid_m0 = 1'b0;
        arvalid_m1 = 1'b1; arid_m1 = 4'h9; araddr_m1 = 32'h2000_0100; arlen_m1 = 4'd7;
        #1;
        chk("rst_seq_grant", arready_m1, 1'b1);
        @(negedge clk);
        arready_s = 5'b10000;
        #1;
        chk("rst_seq_addr", arvalid_s, 5'b10000);
        @(negedge clk);
        arready_s = '0; rvalid_s = 5'b10000; rready_m1 = 1'b1;
        #1;
        chk("rst_seq_data", {rvalid_m1, rready_s}, 6'b1_10000);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_r", {rvalid_m1, rlast_m1, rdata_m1, rid_m1, rready_s, arvalid_s, arready_m0, arready_m1}, 50'h0);
        chk("rst_mid_ar", {arid_s, araddr_s, arlen_s, arsize_s, arburst_s}, 49'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid_s = '0; rready_m1 = 1'b0; arvalid_m1 = 1'b0;
        last_win = 1;
        run_txn(rv, 1, 4);

        for (int k = 0; k < 40; k++) begin
            rv.v0 = 1'($urandom_range(0, 1));
            rv.v1 = 1'($urandom_range(0, 1));
            if (!rv.v0 && !rv.v1) rv.v1 = 1'b1;
            rv.id0 = 4'($urandom); rv.id1 = 4'($urandom);
            rv.a0 = pick_addr(); rv.a1 = pick_addr();
            rv.l0 = 4'($urandom); rv.l1 = 4'($urandom);
            rv.ardly = $urandom_range(0, 3);
            rv.mode = 1;
            w = ref_winner(rv.v0, rv.v1);
            run_txn(rv, w, ref_slave(w ? rv.a1 : rv.a0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Read-side sequencer for the team's AXI bus. It arbitrates the AR channels of masters M0 (instruction fetch) and M1 (data), decodes the address to one of five slaves (S0..S4), forwards the request and routes the R burst back.
- One outstanding read at a time.
- Unmapped addresses are answered internally with DECERR.
- Sits inside the AXI top, between the master ports and the slave ports.

Parameters:
- ID_BITS, 4, master ID width (`AXI_ID_BITS).
- IDS_BITS, 8, slave ID width: {4-bit master tag, master ID}.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width.
- LEN_BITS, 4, burst length width.
- NS, 5, number of slaves.

Ports:
- ACLK  in  1  bus clock.
- ARESETn  in  1  asynchronous active-low reset.
- ARID_M0/ARID_M1  in  ID_BITS  master read ID.
- ARADDR_M0/ARADDR_M1  in  ADDR_BITS  read address.
- ARLEN_M0/ARLEN_M1  in  LEN_BITS  beats-1.
- ARSIZE_M0/ARSIZE_M1  in  3  beat size.
- ARBURST_M0/ARBURST_M1  in  2  burst type.
- ARVALID_M0/ARVALID_M1  in  1  request valid.
- ARREADY_M0/ARREADY_M1  out  1  request accepted.
- RID_M0/RID_M1  out  ID_BITS  response ID.
- RDATA_M0/RDATA_M1  out  DATA_BITS  read data.
- RRESP_M0/RRESP_M1  out  2  response code.
- RLAST_M0/RLAST_M1  out  1  last beat.
- RVALID_M0/RVALID_M1  out  1  beat valid.
- RREADY_M0/RREADY_M1  in  1  master accepts beat.
- ARID_S  out  IDS_BITS  shared to all slaves.
- ARADDR_S  out  ADDR_BITS  shared.
- ARLEN_S  out  LEN_BITS  shared.
- ARSIZE_S  out  3  shared.
- ARBURST_S  out  2  shared.
- ARVALID_S  out  NS  one-hot per slave.
- ARREADY_S  in  NS  per slave.
- RID_S  in  NS*IDS_BITS  packed, slave i at [i*IDS_BITS +: IDS_BITS].
- RDATA_S  in  NS*DATA_BITS  packed.
- RRESP_S  in  NS*2  packed.
- RLAST_S  in  NS  per slave.
- RVALID_S  in  NS  per slave.
- RREADY_S  out  NS  per slave.

Behaviour:
- Clocking: all state on posedge ACLK; async clear on ARESETn low.
- Reset values: all outputs 0 except last-grant register = M1, so M0 wins the first tie. State = IDLE.
- Reset mid-burst: abandon the transaction immediately; no beats are replayed.
- Decode (on the latched address):
  - S0 ROM 0x0000_0000–0x0000_1FFF
  - S1 IM 0x0001_0000–0x0001_FFFF
  - S2 DM 0x0002_0000–0x0002_FFFF
  - S3 Sctrl 0x1000_0000–0x1000_03FF
  - S4 DRAM 0x2000_0000–0x201F_FFFF
  - Any other address: no hit.
- States: IDLE, ADDR, DATA, DERR.
- IDLE:
  - If any ARVALID_Mx is high, grant one master. A single requester wins. If both request, the master not granted last wins (round-robin).
  - ARREADY of the granted master is combinationally 1 in that cycle; the other master sees 0.
  - Latch ID, ADDR, LEN, SIZE, BURST, grant and decoded slave index.
  - Go to ADDR on a hit, DERR on a miss.
  - No ARREADY outside IDLE.
- ADDR:
  - ARVALID_S[sel]=1; the shared AR buses carry the latched fields.
  - ARID_S = {tag, ID} with tag 4'b0001 for M0 and 4'b0010 for M1.
  - Hold all fields stable until ARREADY_S[sel]; that cycle → DATA.
- DATA:
  - Granted master's RDATA/RRESP/RLAST/RVALID = slave sel's signals.
  - RID_Mg = RID_S[sel][ID_BITS-1:0].
  - RREADY_S[sel] = RREADY_Mg; every other RREADY_S bit and every non-granted master R output is 0.
  - On RVALID & RREADY & RLAST → IDLE.
  - A beat with RLAST=0 stays in DATA regardless of beat count.
- DERR:
  - Granted master sees RVALID=1, RRESP=2'b11, RDATA=0, RID = latched ID.
  - A LEN_BITS beat counter starts at 0 and increments on each handshake.
  - RLAST=1 when counter == latched LEN.
  - Handshake with RLAST → IDLE and counter cleared.
  - No slave is touched.
- Handshakes: a master that drops ARVALID before grant is simply not granted; valid/data stability is the masters' responsibility.
- Latency:
  - AR reaches the slave 1 cycle after master acceptance.
  - R is forwarded combinationally (0 cycles).
  - 1 IDLE cycle after every RLAST; back-to-back bursts have a 1-cycle bubble.
- Last-grant update: on every IDLE grant.

Test Plan:
- M0 ARADDR=0x0001_0040, LEN=3 → ARREADY_M0 in grant cycle; next cycle ARVALID_S[1]=1, ARID_S=0x1<id>; 4 beats routed to M0; RLAST_M0 on 4th; back in IDLE.
- M0 and M1 both valid in the first cycle after reset → M0 granted; after its RLAST, M1 granted; with both still valid, grants alternate M0, M1, M0.
- M1 ARADDR=0x3000_0000, LEN=2 → no ARVALID_S bit set; 3 beats RRESP=2'b11, RDATA=0, RLAST only on beat 3; RREADY_M1 held low for 2 cycles mid-burst → counter holds.
- Slave 4 with ARREADY_S[4] delayed 5 cycles → AR fields stable for all 5 cycles; ARREADY_M1 is never reasserted meanwhile.
- Master RREADY toggling on S2 burst → RREADY_S[2] mirrors it exactly; RREADY_S other bits remain 0.
- ARESETn low mid-DATA on S4 → all outputs 0 immediately; after release, a new M1 request is granted normally.
